delta_interleave_arbiter: RTL
=============================

# delta_interleave_arbiter

Two-requester scheduler for the shared signed previous-value/delta stage of the digital video sample path. Accepts signed samples from channel A and channel B over valid/ready handshakes and grants one per cycle. It keeps a per-channel previous-sample register and emits the sample, its channel's previous sample, and their signed difference through a single registered output stage with backpressure. It replaces a fixed A/B toggling scheme with arbitration that honours both requesters and the downstream consumer.

## Interface
- `WIDTH`, default 4: signed sample width; the delta is `WIDTH+1` bits.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `a_valid` in 1: channel A sample offered.
- `a_value` in WIDTH: channel A signed sample.
- `a_ready` out 1: channel A sample accepted this cycle when high together with `a_valid`.
- `b_valid` in 1: channel B sample offered.
- `b_value` in WIDTH: channel B signed sample.
- `b_ready` out 1: channel B sample accepted this cycle when high together with `b_valid`.
- `out_valid` out 1: output holds a result.
- `out_ready` in 1: consumer takes the result when high together with `out_valid`.
- `out_channel` out 1: source of the result; 0 = A, 1 = B.
- `out_value` out WIDTH: accepted sample, signed.
- `out_prev` out WIDTH: previous sample of the same channel, signed.
- `out_delta` out WIDTH+1: `out_value - out_prev`, signed, full precision with no wrap.

## Operation
- **State:**
  - `prev_a` and `prev_b` (WIDTH, signed).
  - Preference pointer `pref` (0 = A).
  - Output register: `out_valid`, `out_channel`, `out_value`, `out_prev`, `out_delta`.
- **Output slot:** `can_accept = !out_valid || out_ready`.
- **Default grant (round-robin, work-conserving):**
  - Both channels valid: grant the channel `pref` names.
  - Only one channel valid: grant that channel.
  - After any grant, `pref` becomes the other channel.
- **Ready signals:** `a_ready`/`b_ready` is high only for the granted channel and only when `can_accept`.
  - Both are combinational from the valids, `pref` and `can_accept`.
  - Neither depends on `a_value`/`b_value`.
- **On acceptance of channel c with sample x:**
  - Output register loads `out_channel=c`, `out_value=x`, `out_prev=prev_c`.
  - `out_delta` loads the sign-extended `x - prev_c`.
  - `prev_c <= x`. The other channel's prev register is unchanged.
  - `out_valid <= 1`.
- **Output drained with no new acceptance:** `out_valid <= 0`. The data fields hold their last values.
- **Output stalled** (`out_valid && !out_ready`):
  - Output register holds.
  - Both readies are low.
  - `pref` and the prev registers are unchanged.
- **Reset values:**
  - `out_valid=0`, `out_channel=0`, `out_value=0`, `out_prev=0`, `out_delta=0`.
  - `prev_a=0`, `prev_b=0`, `pref=A`.
  - `a_ready` and `b_ready` read 0 in every cycle where `resetn` is low.
- **Reset mid-operation:** a pending unconsumed result is discarded, and channel history restarts from 0.

## Timing
- **Latency:** exactly 1 cycle from the accept edge to `out_valid` with the corresponding data.
- **Throughput:** 1 result per cycle with `out_ready` held high. Under continuous double demand the grants go A, B, A, B…
- **Output stability:** `out_*` fields are stable while `out_valid && !out_ready`.
- **Simultaneous drain and accept:** in the same cycle, the new result replaces the drained one, leaving no bubble.
- **Delta range:** −(2^WIDTH − 1) to +(2^WIDTH − 1). For WIDTH=4 this is −15 to +15.

## Configuration
- **`DELTA_STRICT_ALTERNATE_EN` defined:** the grant strictly alternates A, B, A, B, starting at A after reset.
  - Only the scheduled channel's ready may assert.
  - If the scheduled channel is not valid, nothing is granted, even if the other channel is valid.
  - The schedule toggles only on acceptance.
- **`DELTA_STRICT_ALTERNATE_EN` undefined:** the work-conserving round-robin described above.

## Test plan
- **Reset clears state:**
  - Stimulus: hold `resetn=0` 3 cycles, then release with no valids.
  - Response: all outputs 0; first A sample 3 gives `out_prev=0`, `out_delta=+3`.
- **Per-channel history:**
  - Stimulus: A=3, B=−2, A=−8, B=7, all back-to-back with `out_ready=1`.
  - Response: deltas +3, −2, −11, +9; `out_channel` 0, 1, 0, 1; each result 1 cycle after its accept.
- **Extreme arithmetic:**
  - Stimulus: A=7, then A=−8, then A=7.
  - Response: deltas +7, −15, +15 (5-bit, no wrap).
- **Backpressure:**
  - Stimulus: `out_ready=0` for 4 cycles with A and B both valid.
  - Response: exactly one accept, then both readies low; output stable; on release, the other channel is granted the next cycle.
- **Single requester (default build):**
  - Stimulus: B valid continuously, A idle.
  - Response: B accepted every cycle.
  - Strict build: B is never accepted until A supplies a sample.
- **Reset mid-stream:**
  - Stimulus: pull `resetn` low while `out_valid=1` and stalled.
  - Response: next cycle `out_valid=0` and prevs 0; next A sample 5 gives delta +5.

Source files
------------

// File: rtl/delta_interleave_arbiter_if.sv
// Handshake bundle for delta_interleave_arbiter: two sample requesters and one result consumer.
// slave = arbiter side, master = requester/consumer side.
interface delta_interleave_arbiter_if #(
   parameter int WIDTH = 4
);
   logic                    a_valid;
   logic signed [WIDTH-1:0] a_value;
   logic                    a_ready;
   logic                    b_valid;
   logic signed [WIDTH-1:0] b_value;
   logic                    b_ready;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_channel;
   logic signed [WIDTH-1:0] out_value;
   logic signed [WIDTH-1:0] out_prev;
   logic signed [WIDTH:0]   out_delta;

   modport slave (
      input  a_valid, a_value, b_valid, b_value, out_ready,
      output a_ready, b_ready, out_valid, out_channel, out_value, out_prev, out_delta
   );

   modport master (
      output a_valid, a_value, b_valid, b_value, out_ready,
      input  a_ready, b_ready, out_valid, out_channel, out_value, out_prev, out_delta
   );
endinterface

// File: rtl/delta_interleave_arbiter.sv
// Two-channel arbiter feeding a registered previous-value/delta stage with backpressure.
// Define DELTA_STRICT_ALTERNATE_EN for strict A/B alternation instead of work-conserving round-robin.
module delta_interleave_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   delta_interleave_arbiter_if.slave bus
);

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_t;

   sel_t pref;
   sel_t pref_next;

   logic signed [WIDTH-1:0] prev_a;
   logic signed [WIDTH-1:0] prev_b;

   logic                    out_valid_r;
   logic                    out_channel_r;
   logic signed [WIDTH-1:0] out_value_r;
   logic signed [WIDTH-1:0] out_prev_r;
   logic signed [WIDTH:0]   out_delta_r;

   logic                    can_accept;
   logic                    grant_a;
   logic                    grant_b;
   logic                    ready_a;
   logic                    ready_b;
   logic signed [WIDTH-1:0] sel_value;
   logic signed [WIDTH-1:0] sel_prev;
   logic signed [WIDTH:0]   delta_next;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pref <= SEL_A;
      end else begin
         pref <= pref_next;
      end
   end

   always_comb begin
      can_accept = !out_valid_r || bus.out_ready;
`ifdef DELTA_STRICT_ALTERNATE_EN
      grant_a = bus.a_valid && (pref == SEL_A);
      grant_b = bus.b_valid && (pref == SEL_B);
`else
      grant_a = bus.a_valid && (!bus.b_valid || (pref == SEL_A));
      grant_b = bus.b_valid && (!bus.a_valid || (pref == SEL_B));
`endif
      // Readies are forced low throughout reset, independent of the registered state.
      ready_a = resetn && can_accept && grant_a;
      ready_b = resetn && can_accept && grant_b;

      pref_next = pref;
      if (ready_a) begin
         pref_next = SEL_B;
      end else if (ready_b) begin
         pref_next = SEL_A;
      end

      sel_value  = ready_b ? bus.b_value : bus.a_value;
      sel_prev   = ready_b ? prev_b : prev_a;
      delta_next = {sel_value[WIDTH-1], sel_value} - {sel_prev[WIDTH-1], sel_prev};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         prev_a        <= '0;
         prev_b        <= '0;
         out_valid_r   <= 1'b0;
         out_channel_r <= 1'b0;
         out_value_r   <= '0;
         out_prev_r    <= '0;
         out_delta_r   <= '0;
      end else begin
         if (ready_a) begin
            prev_a <= bus.a_value;
         end
         if (ready_b) begin
            prev_b <= bus.b_value;
         end
         if (ready_a || ready_b) begin
            out_valid_r   <= 1'b1;
            out_channel_r <= ready_b;
            out_value_r   <= sel_value;
            out_prev_r    <= sel_prev;
            out_delta_r   <= delta_next;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign bus.a_ready     = ready_a;
   assign bus.b_ready     = ready_b;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_channel = out_channel_r;
   assign bus.out_value   = out_value_r;
   assign bus.out_prev    = out_prev_r;
   assign bus.out_delta   = out_delta_r;

endmodule
